// File: rtl/smaesh_share_encoder_if.sv
// Stream bundle between the share encoder and its neighbours: plaintext words
// in, randomness in, masked shares out. The parameter d is the number of shares.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

interface smaesh_share_encoder_if #(
  parameter int unsigned d = `DEFAULTSHARES
);
  logic                   in_word_valid;
  logic                   in_word_ready;
  logic [31:0]            in_word;
  logic                   rnd_valid;
  logic                   rnd_ready;
  logic [128*(d-1)-1:0]   rnd_data;
  logic [128*d-1:0]       out_shares_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  // Environment side: supplies words and randomness, sinks shares.
  modport master (
    output in_word_valid, in_word, rnd_valid, rnd_data, out_ready,
    input  in_word_ready, rnd_ready, out_shares_data, out_valid, busy
  );

  // Encoder side.
  modport slave (
    input  in_word_valid, in_word, rnd_valid, rnd_data, out_ready,
    output in_word_ready, rnd_ready, out_shares_data, out_valid, busy
  );
endinterface

// File: rtl/smaesh_share_encoder.sv
// Boolean share encoder for the masked AES core. Collects four 32-bit plaintext
// words, draws one fresh mask word per block and registers d shares:
// share i = r_i (i >= 1), share 0 = pt ^ r_1 ^ ... ^ r_{d-1}.
// Build option SMAESH_SHARE_ENCODER_OVERLAP_EN: when defined, the next block is
// collected while the output register is still waiting for the downstream.
`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module smaesh_share_encoder #(
  parameter int unsigned d = `DEFAULTSHARES
) (
  input  logic                  clk,
  input  logic                  rst,
  smaesh_share_encoder_if.slave bus
);

  localparam logic [0:0] COLLECT  = 1'b0;
  localparam logic [0:0] WAIT_RND = 1'b1;

  logic [0:0]       state;
  logic [1:0]       cnt;
  logic [127:0]     pt;
  logic [128*d-1:0] shares_q;
  logic             out_valid_q;

  logic             word_hs;
  logic             rnd_hs;
  logic             drain;
  logic             collect_ok;
  logic [127:0]     mask_acc;
  logic [128*d-1:0] shares_d;

`ifdef SMAESH_SHARE_ENCODER_OVERLAP_EN
  // Plaintext and output registers are separate, so collection ignores out_valid.
  assign collect_ok = 1'b1;
`else
  // Collection waits until the previous block has left the output register.
  assign collect_ok = ~out_valid_q;
`endif

  // Ready/valid depend only on registered state, out_ready and reset.
  assign bus.in_word_ready   = rst & (state == COLLECT) & collect_ok;
  assign bus.rnd_ready       = (state == WAIT_RND) & (~out_valid_q | bus.out_ready);
  assign bus.out_valid       = out_valid_q;
  assign bus.out_shares_data = shares_q;
  assign bus.busy            = (state == WAIT_RND) | (cnt != 2'd0) | out_valid_q;

  assign word_hs = bus.in_word_valid & bus.in_word_ready;
  assign rnd_hs  = bus.rnd_valid & bus.rnd_ready;
  assign drain   = out_valid_q & bus.out_ready;

  // Fold all masks into share 0; the masks themselves are shares 1..d-1.
  always_comb begin
    mask_acc = '0;
    for (int unsigned i = 1; i < d; i++) mask_acc ^= bus.rnd_data[128*(i-1) +: 128];
    shares_d = {bus.rnd_data, pt ^ mask_acc};
  end

  // Collection FSM, plaintext register and output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= COLLECT;
      cnt         <= 2'd0;
      pt          <= '0;
      shares_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (word_hs) begin
        pt[{cnt, 5'd0} +: 32] <= bus.in_word;
        cnt                   <= cnt + 2'd1;
        if (cnt == 2'd3) state <= WAIT_RND;
      end
      // A reload in the same edge as a drain keeps out_valid high.
      if (rnd_hs) begin
        shares_q    <= shares_d;
        out_valid_q <= 1'b1;
        pt          <= '0;
        state       <= COLLECT;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_smaesh_share_encoder.sv
// Scoreboard bench for smaesh_share_encoder: a d=2 and a d=3 instance run in
// lock-step from the same stimulus; the d=3 instance sees r1 = r2.
module tb_smaesh_share_encoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  smaesh_share_encoder_if #(.d(2)) bus2();
  smaesh_share_encoder_if #(.d(3)) bus3();

  smaesh_share_encoder #(.d(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  smaesh_share_encoder #(.d(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  assign bus3.in_word_valid = bus2.in_word_valid;
  assign bus3.in_word       = bus2.in_word;
  assign bus3.rnd_valid     = bus2.rnd_valid;
  assign bus3.rnd_data      = {bus2.rnd_data, bus2.rnd_data};
  assign bus3.out_ready     = bus2.out_ready;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int t_word = 0;
  int t_out  = 0;
  int widx   = 0;
  int words_acc = 0;
  logic words_done;
  logic [127:0] pt_acc = '0;
  logic [255:0] last2;
  logic [255:0] q2[$];
  logic [383:0] q3[$];
  logic [127:0] ptq[$];

  localparam logic [127:0] PT  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] NPT = 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a block is handed downstream.
  always @(negedge clk) begin
    if (bus2.out_valid && bus2.out_ready) begin
      if (q2.size() == 0) chk("out2_unexpected", 384'd1, 384'd0);
      else begin
        logic [255:0] e;
        logic [127:0] p;
        e = q2.pop_front();
        p = ptq.pop_front();
        t_out = cyc;
        last2 = bus2.out_shares_data;
        chk("out2_shares", bus2.out_shares_data, e);
        chk("out2_xor", bus2.out_shares_data[127:0] ^ bus2.out_shares_data[255:128], p);
      end
    end
    if (bus3.out_valid && bus3.out_ready) begin
      if (q3.size() == 0) chk("out3_unexpected", 384'd1, 384'd0);
      else chk("out3_shares", bus3.out_shares_data, q3.pop_front());
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    bus2.in_word_valid = 1'b1;
    bus2.in_word = w;
    while (!bus2.in_word_ready && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) begin
      chk("word_timeout", 384'd1, 384'd0);
      bus2.in_word_valid = 1'b0;
    end else begin
      t_word = cyc;
      @(posedge clk);
      pt_acc[32*widx +: 32] = w;
      widx = (widx + 1) % 4;
      words_acc++;
      #1 bus2.in_word_valid = 1'b0;
    end
  endtask

  task automatic send_rnd(input logic [127:0] r);
    int n = 0;
    @(negedge clk);
    bus2.rnd_valid = 1'b1;
    bus2.rnd_data = r;
    while (!bus2.rnd_ready && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) begin
      chk("rnd_timeout", 384'd1, 384'd0);
      bus2.rnd_valid = 1'b0;
    end else begin
      @(posedge clk);
      q2.push_back({r, pt_acc ^ r});
      ptq.push_back(pt_acc);
      q3.push_back({r, r, pt_acc});
      pt_acc = '0;
      widx = 0;
      #1 bus2.rnd_valid = 1'b0;
    end
  endtask

  task automatic send_pt(input logic [127:0] p);
    for (int k = 0; k < 4; k++) send_word(p[32*k +: 32]);
  endtask

  task automatic set_ordy(input logic v);
    @(posedge clk);
    #1 bus2.out_ready = v;
  endtask

  task automatic drain_wait();
    int n = 0;
    while ((q2.size() != 0 || q3.size() != 0 || bus2.out_valid) && n < 60) begin
      @(negedge clk); n++;
    end
    if (n >= 60) chk("drain_timeout", 384'd1, 384'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int t1;
    logic [255:0] snap;
    bus2.in_word_valid = 1'b0;
    bus2.in_word = '0;
    bus2.rnd_valid = 1'b0;
    bus2.rnd_data = '0;
    bus2.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_word_ready", bus2.in_word_ready, 0);
    chk("rst_rnd_ready", bus2.rnd_ready, 0);
    chk("rst_out_valid", bus2.out_valid, 0);
    chk("rst_busy", bus2.busy, 0);
    chk("rst_shares", bus2.out_shares_data, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_word_ready", bus2.in_word_ready, 1);

    // Zero masks: share0 = pt, share1 = 0; latency from the first word.
    send_word(PT[31:0]);
    t0 = t_word;
    send_word(PT[63:32]);
    send_word(PT[95:64]);
    send_word(PT[127:96]);
    send_rnd('0);
    drain_wait();
    chk("latency", t_out - t0, 5);
    chk("zero_mask_shares", last2, {128'h0, PT});

    // All-ones masks: share0 = ~pt, share1 = all ones.
    send_pt(PT);
    send_rnd({128{1'b1}});
    drain_wait();
    chk("ones_mask_shares", last2, {{128{1'b1}}, NPT});

    // Back-to-back blocks: spacing between first words.
    send_pt(128'h11111111_22222222_33333333_44444444);
    t0 = t_word - 3;
    send_rnd(128'h0123456789ABCDEF_FEDCBA9876543210);
    send_pt(128'hDEADBEEF_CAFEF00D_A5A5A5A5_5A5A5A5A);
    t1 = t_word - 3;
    send_rnd(128'h80000000_00000000_00000000_00000001);
    send_pt(128'h00000000_FFFFFFFF_00000000_FFFFFFFF);
    send_rnd(128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0);
    drain_wait();
`ifdef SMAESH_SHARE_ENCODER_OVERLAP_EN
    chk("block_period", t1 - t0, 5);
`else
    chk("block_period", t1 - t0, 6);
`endif

    // Downstream stall of 10 cycles.
    set_ordy(1'b0);
    send_pt(128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
    send_rnd(128'h55555555_AAAAAAAA_12345678_9ABCDEF0);
    @(negedge clk);
    snap = bus2.out_shares_data;
    words_acc = 0;
    words_done = 1'b0;
    fork
      begin
        send_pt(128'h01010101_02020202_03030303_04040404);
        words_done = 1'b1;
      end
    join_none
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_stable", bus2.out_shares_data, snap);
      chk("stall_out_valid", bus2.out_valid, 1);
      chk("stall_rnd_ready", bus2.rnd_ready, 0);
`ifndef SMAESH_SHARE_ENCODER_OVERLAP_EN
      chk("stall_in_word_ready", bus2.in_word_ready, 0);
`endif
    end
`ifdef SMAESH_SHARE_ENCODER_OVERLAP_EN
    chk("stall_words_accepted", words_acc, 4);
    fork
      send_rnd(128'hFEEDFACE_0BADC0DE_77777777_88888888);
    join_none
    @(negedge clk);
    chk("stall_rnd_blocked", bus2.rnd_ready, 0);
    set_ordy(1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("drain_reload_out_valid", bus2.out_valid, 1);
`else
    chk("stall_words_accepted", words_acc, 0);
    set_ordy(1'b1);
    for (int n = 0; n < 60 && !words_done; n++) @(negedge clk);
    chk("stall_words_done", words_done, 1);
    send_rnd(128'hFEEDFACE_0BADC0DE_77777777_88888888);
`endif
    drain_wait();

    // Randomness withheld for 5 cycles in WAIT_RND.
    send_pt(128'h9ABCDEF0_12345678_0F1E2D3C_4B5A6978);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("norand_out_valid", bus2.out_valid, 0);
      chk("norand_in_word_ready", bus2.in_word_ready, 0);
      chk("norand_rnd_ready", bus2.rnd_ready, 1);
    end
    send_rnd(128'hC3C3C3C3_3C3C3C3C_96969696_69696969);
    @(negedge clk);
    chk("rnd_once_ready", bus2.rnd_ready, 0);
    drain_wait();

    // Reset after two words discards the partial block.
    send_word(32'hAAAAAAAA);
    send_word(32'h55555555);
    @(negedge clk);
    chk("partial_busy", bus2.busy, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_busy", bus2.busy, 0);
      chk("midrst_in_word_ready", bus2.in_word_ready, 0);
      chk("midrst_out_valid", bus2.out_valid, 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    pt_acc = '0;
    widx = 0;
    send_pt(128'h76543210_FEDCBA98_89ABCDEF_01234567);
    send_rnd(128'h00FF00FF_FF00FF00_0000FFFF_FFFF0000);
    drain_wait();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
